// File: rtl/ours_arb_pkg.sv
// Shared types and helpers for the arbiter output buffer.
// The buffer-state encoding matches {main_vld, skid_vld} so it decodes without logic.
package ours_arb_pkg;

    typedef enum logic [1:0] {
        ARB_BUF_EMPTY = 2'b00,
        ARB_BUF_ONE   = 2'b10,
        ARB_BUF_FULL  = 2'b11
    } arb_buf_state_t;

    function automatic int ours_src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ours_vld_rdy_onehot_mux.sv
// AND-OR payload mux driven by a one-hot-or-zero grant, plus a one-hot-to-binary
// encoder that exists only when OURS_ARB_OUT_BUF_SRC_EN is defined.
module ours_vld_rdy_onehot_mux
    import ours_arb_pkg::*;
#(
    parameter int N_INPUT = 2,
    parameter int DATA_W  = 64
`ifdef OURS_ARB_OUT_BUF_SRC_EN
    , localparam int SRC_W = ours_src_w(N_INPUT)
`endif
) (
    input  logic [N_INPUT-1:0]             grt,
    input  logic [N_INPUT-1:0][DATA_W-1:0] dat,
`ifdef OURS_ARB_OUT_BUF_SRC_EN
    output logic [SRC_W-1:0]               sel_src,
`endif
    output logic [DATA_W-1:0]              sel_dat
);

    // A zero grant yields an all-zero payload.
    always_comb begin
        sel_dat = '0;
        for (int i = 0; i < N_INPUT; i++)
            sel_dat = sel_dat | (dat[i] & {DATA_W{grt[i]}});
    end

`ifdef OURS_ARB_OUT_BUF_SRC_EN
    always_comb begin
        sel_src = '0;
        for (int i = 0; i < N_INPUT; i++)
            if (grt[i]) sel_src = sel_src | SRC_W'(i);
    end
`endif

endmodule

// File: rtl/ours_vld_rdy_arb_out_buf.sv
// Grant-driven payload mux feeding a two-entry skid buffer: registered out_vld/out_dat
// and a flop-driven arb_rdy. Define OURS_ARB_OUT_BUF_SRC_EN to carry the source index.
module ours_vld_rdy_arb_out_buf
    import ours_arb_pkg::*;
#(
    parameter int N_INPUT = 2,
    parameter int DATA_W  = 64
`ifdef OURS_ARB_OUT_BUF_SRC_EN
    , localparam int SRC_W = ours_src_w(N_INPUT)
`endif
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [N_INPUT-1:0]             in_vld,
    input  logic [N_INPUT-1:0][DATA_W-1:0] in_dat,
    input  logic [N_INPUT-1:0]             arb_grt,
    output logic                           arb_rdy,
    output logic [N_INPUT-1:0]             in_rdy,
    output logic                           out_vld,
    output logic [DATA_W-1:0]              out_dat,
`ifdef OURS_ARB_OUT_BUF_SRC_EN
    output logic [SRC_W-1:0]               out_src,
`endif
    input  logic                           out_rdy
);

`ifdef OURS_ARB_OUT_BUF_SRC_EN
    localparam int ENT_W = DATA_W + SRC_W;
`else
    localparam int ENT_W = DATA_W;
`endif

    logic              main_vld, skid_vld, acc;
    logic [ENT_W-1:0]  main_ent, skid_ent, pay_ent;
    logic [DATA_W-1:0] pay_dat;
    arb_buf_state_t    buf_st;

`ifdef OURS_ARB_OUT_BUF_SRC_EN
    logic [SRC_W-1:0]  pay_src;

    ours_vld_rdy_onehot_mux #(.N_INPUT(N_INPUT), .DATA_W(DATA_W)) u_mux (
        .grt(arb_grt), .dat(in_dat), .sel_src(pay_src), .sel_dat(pay_dat)
    );
    assign pay_ent            = {pay_src, pay_dat};
    assign {out_src, out_dat} = main_ent;
`else
    ours_vld_rdy_onehot_mux #(.N_INPUT(N_INPUT), .DATA_W(DATA_W)) u_mux (
        .grt(arb_grt), .dat(in_dat), .sel_dat(pay_dat)
    );
    assign pay_ent = pay_dat;
    assign out_dat = main_ent;
`endif

    // Ready depends only on skid occupancy, never on out_rdy.
    assign arb_rdy = ~skid_vld;
    assign in_rdy  = arb_grt & {N_INPUT{arb_rdy}};
    assign acc     = arb_rdy & (|arb_grt);
    assign out_vld = main_vld;
    assign buf_st  = arb_buf_state_t'({main_vld, skid_vld});

    always_ff @(posedge clk) begin
        if (!rstn) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_ent <= '0;
            skid_ent <= '0;
        end else begin
            case (buf_st)
                ARB_BUF_EMPTY: begin
                    if (acc) begin
                        main_vld <= 1'b1;
                        main_ent <= pay_ent;
                    end
                end
                ARB_BUF_ONE: begin
                    if (acc && out_rdy) begin
                        main_ent <= pay_ent;
                    end else if (acc) begin
                        skid_vld <= 1'b1;
                        skid_ent <= pay_ent;
                    end else if (out_rdy) begin
                        main_vld <= 1'b0;
                    end
                end
                ARB_BUF_FULL: begin
                    if (out_rdy) begin
                        main_ent <= skid_ent;
                        skid_vld <= 1'b0;
                    end
                end
                default: begin
                    main_vld <= 1'b0;
                    skid_vld <= 1'b0;
                end
            endcase
        end
    end

    a_grt_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(arb_grt));
    a_grt_vld:    assert property (@(posedge clk) disable iff (!rstn) (arb_grt & ~in_vld) == '0);
    a_buf_legal:  assert property (@(posedge clk) disable iff (!rstn)
                                   buf_st inside {ARB_BUF_EMPTY, ARB_BUF_ONE, ARB_BUF_FULL});

endmodule

// File: tb/tb_ours_vld_rdy_arb_out_buf.sv
// Scoreboard bench for ours_vld_rdy_arb_out_buf (N_INPUT=2, DATA_W=8): occupancy and
// head-of-queue of the expected FIFO give the required arb_rdy, out_vld and out_dat.
module tb_ours_vld_rdy_arb_out_buf;

    localparam int N = 2;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] dat;
        logic [0:0]   src;
    } ent_t;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [N-1:0]      in_vld = '0;
    logic [N-1:0][W-1:0] in_dat = '0;
    logic [N-1:0]      arb_grt = '0;
    logic              arb_rdy;
    logic [N-1:0]      in_rdy;
    logic              out_vld;
    logic [W-1:0]      out_dat;
    logic              out_rdy = 1'b0;
`ifdef OURS_ARB_OUT_BUF_SRC_EN
    logic [0:0]        out_src;
`endif

    int   checks = 0;
    int   errs   = 0;
    ent_t sb[$];
    logic hold_pend = 1'b0;
    logic [W-1:0] hold_dat = '0;

    always #5 clk = ~clk;

    ours_vld_rdy_arb_out_buf #(.N_INPUT(N), .DATA_W(W)) dut (
        .clk(clk), .rstn(rstn), .in_vld(in_vld), .in_dat(in_dat), .arb_grt(arb_grt),
        .arb_rdy(arb_rdy), .in_rdy(in_rdy), .out_vld(out_vld), .out_dat(out_dat),
`ifdef OURS_ARB_OUT_BUF_SRC_EN
        .out_src(out_src),
`endif
        .out_rdy(out_rdy)
    );

    // Checks outputs against the model, updates the model for the coming edge,
    // then advances to the next falling edge.
    task automatic tick();
        logic exp_rdy;
        ent_t e;
        #1;
        if (rstn) begin
            exp_rdy = (sb.size() < 2);
            checks++;
            if (arb_rdy !== exp_rdy) begin
                errs++; $display("FAIL arb_rdy: got %b want %b", arb_rdy, exp_rdy);
            end
            checks++;
            if (in_rdy !== (arb_grt & {N{exp_rdy}})) begin
                errs++; $display("FAIL in_rdy: got %b want %b", in_rdy, arb_grt & {N{exp_rdy}});
            end
            checks++;
            if (out_vld !== (sb.size() != 0)) begin
                errs++; $display("FAIL out_vld: got %b want %b", out_vld, sb.size() != 0);
            end
            if (sb.size() != 0) begin
                checks++;
                if (out_dat !== sb[0].dat) begin
                    errs++; $display("FAIL out_dat: got %h want %h", out_dat, sb[0].dat);
                end
`ifdef OURS_ARB_OUT_BUF_SRC_EN
                checks++;
                if (out_src !== sb[0].src) begin
                    errs++; $display("FAIL out_src: got %0d want %0d", out_src, sb[0].src);
                end
`endif
            end
            if (hold_pend) begin
                checks++;
                if (out_dat !== hold_dat) begin
                    errs++; $display("FAIL stall_hold: got %h want %h", out_dat, hold_dat);
                end
            end
            hold_pend = out_vld && !out_rdy;
            hold_dat  = out_dat;
            if (out_vld && out_rdy && sb.size() != 0) void'(sb.pop_front());
            if (exp_rdy && |arb_grt) begin
                e = '0;
                for (int i = 0; i < N; i++)
                    if (arb_grt[i]) begin
                        e.dat = e.dat | in_dat[i];
                        e.src = 1'(i);
                    end
                sb.push_back(e);
            end
        end
        @(negedge clk);
        if (!rstn) begin
            sb.delete();
            hold_pend = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        in_vld  = '0;
        arb_grt = '0;
        in_dat  = '0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle_inputs();
        tick(); tick();
        rstn = 1'b1;
        #1;
        checks++;
        if (out_vld !== 1'b0) begin errs++; $display("FAIL reset_out_vld: got %b want 0", out_vld); end
        checks++;
        if (arb_rdy !== 1'b1) begin errs++; $display("FAIL reset_arb_rdy: got %b want 1", arb_rdy); end
        checks++;
        if (out_dat !== '0) begin errs++; $display("FAIL reset_out_dat: got %h want 00", out_dat); end
        tick(); tick();
    endtask

    task automatic test_single();
        out_rdy   = 1'b1;
        in_vld    = 2'b01;
        in_dat[0] = 8'hA5;
        arb_grt   = 2'b01;
        #1;
        checks++;
        if (in_rdy !== 2'b01) begin errs++; $display("FAIL single_in_rdy: got %b want 01", in_rdy); end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (out_vld !== 1'b1 || out_dat !== 8'hA5) begin
            errs++; $display("FAIL single_out: got vld=%b dat=%h want vld=1 dat=a5", out_vld, out_dat);
        end
`ifdef OURS_ARB_OUT_BUF_SRC_EN
        checks++;
        if (out_src !== 1'b0) begin errs++; $display("FAIL single_src: got %0d want 0", out_src); end
`endif
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        out_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            idle_inputs();
            arb_grt = (k % 2 == 0) ? 2'b01 : 2'b10;
            in_vld  = arb_grt;
            in_dat[k % 2] = 8'(k + 1);
            #1;
            checks++;
            if (arb_rdy !== 1'b1) begin errs++; $display("FAIL b2b_arb_rdy: got %b want 1", arb_rdy); end
            if (k > 0) begin
                checks++;
                if (out_vld !== 1'b1 || out_dat !== 8'(k)) begin
                    errs++; $display("FAIL b2b_out: got vld=%b dat=%h want vld=1 dat=%h", out_vld, out_dat, 8'(k));
                end
            end
            tick();
        end
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_stall();
        out_rdy   = 1'b0;
        in_vld    = 2'b01;
        arb_grt   = 2'b01;
        in_dat[0] = 8'h11;
        tick();
        in_dat[0] = 8'h22;
        tick();
        #1;
        checks++;
        if (arb_rdy !== 1'b0 || in_rdy !== 2'b00) begin
            errs++; $display("FAIL stall_full: got arb_rdy=%b in_rdy=%b want 0 00", arb_rdy, in_rdy);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_dat !== 8'h11) begin errs++; $display("FAIL stall_dat: got %h want 11", out_dat); end
            tick();
        end
        idle_inputs();
        out_rdy = 1'b1;
        tick();
        #1;
        checks++;
        if (arb_rdy !== 1'b1 || out_dat !== 8'h22) begin
            errs++; $display("FAIL stall_drain: got arb_rdy=%b dat=%h want 1 22", arb_rdy, out_dat);
        end
        tick(); tick();
    endtask

    task automatic test_random();
        int ptr = 0;
        int gi;
        for (int c = 0; c < 10000; c++) begin
            in_vld  = 2'($urandom);
            for (int i = 0; i < N; i++) in_dat[i] = 8'($urandom);
            out_rdy = ($urandom_range(0, 3) != 0);
            arb_grt = '0;
            gi = -1;
            for (int k = 0; k < N; k++)
                if (gi < 0 && in_vld[(ptr + k) % N]) gi = (ptr + k) % N;
            if (gi >= 0) arb_grt[gi] = 1'b1;
            #1;
            if (gi >= 0 && arb_rdy) ptr = (gi + 1) % N;
            tick();
        end
        idle_inputs();
        out_rdy = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (sb.size() != 0) begin errs++; $display("FAIL random_drain: got %0d left want 0", sb.size()); end
    endtask

    task automatic test_reset_full();
        out_rdy   = 1'b0;
        in_vld    = 2'b10;
        arb_grt   = 2'b10;
        in_dat[1] = 8'hAA;
        tick();
        in_dat[1] = 8'hBB;
        tick();
        rstn = 1'b0;
        idle_inputs();
        tick();
        rstn = 1'b1;
        #1;
        checks++;
        if (out_vld !== 1'b0 || arb_rdy !== 1'b1 || out_dat !== '0) begin
            errs++; $display("FAIL reset_full: got vld=%b rdy=%b dat=%h want 0 1 00", out_vld, arb_rdy, out_dat);
        end
        out_rdy = 1'b1;
        for (int k = 0; k < 3; k++) tick();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_full();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
